// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register link: op codes, frame geometry,
// CPLD register addresses and the master sequencer state encoding.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 14;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b11;

  // Register map, kept identical to the slave-side decoder.
  localparam logic [ADDR_BITS-1:0] REG_BOARD_ID   = 14'h0001;
  localparam logic [ADDR_BITS-1:0] REG_PWM0       = 14'h0011;
  localparam logic [ADDR_BITS-1:0] REG_PWM1       = 14'h0012;
  localparam logic [ADDR_BITS-1:0] REG_PWM2       = 14'h0013;
  localparam logic [ADDR_BITS-1:0] REG_PWM3       = 14'h0014;
  localparam logic [ADDR_BITS-1:0] REG_PWM4       = 14'h0015;
  localparam logic [ADDR_BITS-1:0] REG_PWM5       = 14'h0016;
  localparam logic [ADDR_BITS-1:0] REG_VERSION_LO = 14'h001D;
  localparam logic [ADDR_BITS-1:0] REG_VERSION_HI = 14'h001E;
  localparam logic [ADDR_BITS-1:0] REG_PWM_LOAD   = 14'h00FF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_FRAME = 3'd1,
    ST_GAP        = 3'd2,
    ST_DATA_FRAME = 3'd3,
    ST_DONE       = 3'd4
  } master_state_e;

  // Only the two legal op codes can ever be produced from the rw bit.
  function automatic logic [FRAME_BITS-1:0] addr_frame_word(
    input logic                 rw,
    input logic [ADDR_BITS-1:0] addr
  );
    return {(rw ? OP_READ : OP_WRITE), addr};
  endfunction

endpackage

// File: rtl/spi_master_shift16.sv
// One 16-bit mode-0 SPI frame: chip select low, 16 SCLK pulses, MSB first,
// then one further half period before chip select is released.
module spi_master_shift16
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_word,
  input  logic                  miso,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_word,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi
);

  localparam int DIV_W     = $clog2(CLK_DIV);
  localparam int HALF_LAST = 2 * FRAME_BITS;

  logic                  active;
  logic [DIV_W-1:0]      div_cnt;
  logic [5:0]            half_cnt;
  logic [FRAME_BITS-1:0] tx_sr;
  logic                  half_end;

  assign half_end = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  // Strobe on the edge that releases chip select; the sequencer steps on it.
  assign done     = half_end && (half_cnt == 6'(HALF_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_word  <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else if (start && !active) begin
      active   <= 1'b1;
      div_cnt  <= '0;
      half_cnt <= '0;
      cs_n     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= tx_word[FRAME_BITS-1];
      tx_sr    <= {tx_word[FRAME_BITS-2:0], 1'b0};
      rx_word  <= '0;
    end else if (half_end) begin
      div_cnt  <= '0;
      half_cnt <= half_cnt + 6'd1;
      if (done) begin
        active <= 1'b0;
        cs_n   <= 1'b1;
        sclk   <= 1'b0;
        mosi   <= 1'b0;
      end else if (!sclk) begin
        sclk    <= 1'b1;
        rx_word <= {rx_word[FRAME_BITS-2:0], miso};
      end else begin
        // MOSI only moves on the falling edge so it is stable across each rise.
        sclk  <= 1'b0;
        mosi  <= tx_sr[FRAME_BITS-1];
        tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
      end
    end else if (active) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_reg_access.sv
// Register access sequencer: one request becomes an address frame, a fixed
// chip-select-high gap and a data frame, followed by a one-cycle response.
module spi_master_reg_access
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int FRAME_GAP = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic [FRAME_BITS-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [FRAME_BITS-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  // Handshake: a request transfers on a cycle with req_valid && req_ready;
  // req_ready is high only in IDLE, and rsp_valid is a single-cycle pulse.

  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  master_state_e         state, state_next;
  logic                  rw_q;
  logic [FRAME_BITS-1:0] wdata_q;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  gap_last;
  logic                  accept;
  logic                  frame_start;
  logic                  frame_done;
  logic [FRAME_BITS-1:0] tx_word;
  logic [FRAME_BITS-1:0] rx_word;

  assign accept      = (state == ST_IDLE) && req_valid;
  assign gap_last    = (state == ST_GAP) && (gap_cnt == GAP_W'(FRAME_GAP - 1));
  assign frame_start = accept || gap_last;
  // The address frame is built straight from the request so it starts on the
  // accepting edge; everything the data frame needs is captured there too.
  assign tx_word     = (state == ST_IDLE) ? addr_frame_word(req_rw, req_addr)
                                          : (rw_q ? '0 : wdata_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:       if (req_valid)  state_next = ST_ADDR_FRAME;
      ST_ADDR_FRAME: if (frame_done) state_next = ST_GAP;
      ST_GAP:        if (gap_last)   state_next = ST_DATA_FRAME;
      ST_DATA_FRAME: if (frame_done) state_next = ST_DONE;
      ST_DONE:                       state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    rsp_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      gap_cnt   <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        rw_q    <= req_rw;
        wdata_q <= req_wdata;
      end
      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
      if ((state == ST_DATA_FRAME) && frame_done) begin
        rsp_rdata <= rw_q ? rx_word : '0;
      end
    end
  end

  spi_master_shift16 #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (frame_start),
    .tx_word (tx_word),
    .miso    (spi_miso),
    .done    (frame_done),
    .rx_word (rx_word),
    .sclk    (spi_sclk),
    .cs_n    (spi_cs_n),
    .mosi    (spi_mosi)
  );

endmodule
